// File: rtl/sorted_stream_out_if.sv
// Stream bundle around the sorted-vector serializer.
// Input side carries one whole sorted vector per handshake; output side
// carries one element per handshake along with its rank and a last flag.
// The slave modport is the serializer's view; master is the environment's.
interface sorted_stream_out_if #(
  parameter int N  = 5,
  parameter int DW = 8
);
  localparam int IW = $clog2(N);

  logic [DW*N-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_idx;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_idx, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_idx, out_valid, out_last
  );
endinterface

// File: rtl/sorted_stream_out.sv
// Serializer behind the N-input sorting network: captures one sorted vector
// per input handshake and replays it one element per cycle with rank index
// and a last flag.
// Build option: define SORTED_STREAM_DESCEND_EN to emit largest-first
// (rank N-1 down to 0); by default elements go out smallest-first.
module sorted_stream_out #(
  parameter int N  = 5,
  parameter int DW = 8
) (
  input logic               clk,
  input logic               rst,
  sorted_stream_out_if.slave bus
);
  localparam int IW = $clog2(N);

`ifdef SORTED_STREAM_DESCEND_EN
  localparam logic [IW-1:0] FIRST_RANK = IW'(N-1);
  localparam logic [IW-1:0] FINAL_RANK = '0;
`else
  localparam logic [IW-1:0] FIRST_RANK = '0;
  localparam logic [IW-1:0] FINAL_RANK = IW'(N-1);
`endif

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state, state_nxt;
  logic [N-1:0][DW-1:0] buffer;
  logic [IW-1:0]        idx, idx_step;
  logic                 at_final;
  logic                 in_xfer, out_xfer;

  logic                 in_ready, out_valid, out_last;
  logic [DW-1:0]        out_data;
  logic [IW-1:0]        out_idx;

  // idx only ever walks between FIRST_RANK and FINAL_RANK; the step is
  // suppressed on the final rank, so no wrap logic is needed for
  // non-power-of-two N.
  assign at_final = (idx == FINAL_RANK);
  assign in_xfer  = bus.in_valid && in_ready;
  assign out_xfer = out_valid && bus.out_ready;

`ifdef SORTED_STREAM_DESCEND_EN
  assign idx_step = idx - IW'(1);
`else
  assign idx_step = idx + IW'(1);
`endif

  // State register; async reset drops out_valid immediately via the output comb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: a new vector can be taken in IDLE or on the final element's
  // handshake, which keeps back-to-back vectors bubble-free.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_xfer) state_nxt = STREAM;
      STREAM:  if (out_xfer && at_final) state_nxt = in_xfer ? STREAM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Vector buffer and rank pointer; load wins over step (they are exclusive
  // anyway, since a load in STREAM only happens on the final element).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer <= '0;
      idx    <= '0;
    end else if (in_xfer) begin
      buffer <= bus.in_data;
      idx    <= FIRST_RANK;
    end else if (out_xfer && !at_final) begin
      idx    <= idx_step;
    end
  end

  // Outputs: element mux off the buffer; in_ready looks at out_ready only on
  // the final element so in_valid never feeds back into a registered path.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    in_ready  = 1'b1;
    if (state == STREAM) begin
      out_valid = 1'b1;
      out_data  = buffer[idx];
      out_idx   = idx;
      out_last  = at_final;
      in_ready  = at_final && bus.out_ready;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_idx   = out_idx;
  assign bus.out_last  = out_last;
endmodule

// File: tb/tb_sorted_stream_out.sv
// Bench for sorted_stream_out: table-driven vectors, hand-written corner
// sequences (back-to-back, backpressure, reset mid-stream) and a random
// phase checked against a queue-based model of the emitted element stream.
module tb_sorted_stream_out;
  localparam int N  = 5;
  localparam int DW = 8;
  localparam int IW = $clog2(N);

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct {
    vec_t vin;
    vec_t exp_asc;
    bit   scramble;
  } rec_t;
  typedef struct {
    logic [DW-1:0] d;
    logic [IW-1:0] i;
    logic          l;
  } el_t;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  sorted_stream_out_if #(.N(N), .DW(DW)) bus();

  sorted_stream_out #(.N(N), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // p-th emitted element comes from this rank
  function automatic int rank_at(input int p);
`ifdef SORTED_STREAM_DESCEND_EN
    return N - 1 - p;
`else
    return p;
`endif
  endfunction

  task automatic check_elem(input string tag, input int p, input vec_t exp_asc);
    int r;
    r = rank_at(p);
    check({tag, " valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, " data"},  32'(bus.out_data),  32'(exp_asc[r]));
    check({tag, " idx"},   32'(bus.out_idx),   32'(r));
    check({tag, " last"},  32'(bus.out_last),  32'(p == N - 1));
  endtask

  // One isolated vector with out_ready held high
  task automatic run_vec(input rec_t r, input string tag);
    @(posedge clk); #1;
    bus.in_data   = r.vin;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, " idle in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, " idle out_valid"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (r.scramble) bus.in_data = {N{DW'(8'h55)}};
    for (int p = 0; p < N; p++) begin
      @(negedge clk);
      check_elem(tag, p, r.exp_asc);
      check({tag, " in_ready"}, 32'(bus.in_ready), 32'(p == N - 1));
      @(posedge clk);
    end
    @(negedge clk);
    check({tag, " done out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, " done in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  function automatic vec_t rand_sorted();
    logic [DW-1:0] a[N];
    logic [DW-1:0] t;
    vec_t v;
    for (int k = 0; k < N; k++) a[k] = DW'($urandom_range(0, 255));
    for (int k = 1; k < N; k++)
      for (int j = k; j > 0 && a[j-1] > a[j]; j--) begin
        t = a[j]; a[j] = a[j-1]; a[j-1] = t;
      end
    for (int k = 0; k < N; k++) v[k] = a[k];
    return v;
  endfunction

  rec_t tbl[4];
  el_t  q[$];

  initial begin
    vec_t va, vb, pv;
    bit   pat[12];
    int   pos, cyc;
    bit   pend, ev, eir;

    tbl[0] = '{vin: {8'hFF, 8'h20, 8'h0A, 8'h07, 8'h03}, exp_asc: {8'hFF, 8'h20, 8'h0A, 8'h07, 8'h03}, scramble: 1'b0};
    tbl[1] = '{vin: {8'hFF, 8'h20, 8'h0A, 8'h07, 8'h03}, exp_asc: {8'hFF, 8'h20, 8'h0A, 8'h07, 8'h03}, scramble: 1'b1};
    tbl[2] = '{vin: {8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, exp_asc: {8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, scramble: 1'b0};
    tbl[3] = '{vin: {8'hFF, 8'hFE, 8'h80, 8'h10, 8'h00}, exp_asc: {8'hFF, 8'hFE, 8'h80, 8'h10, 8'h00}, scramble: 1'b1};
    pat = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1};

    // reset state
    rst = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_data",  32'(bus.out_data),  32'd0);
    check("rst out_idx",   32'(bus.out_idx),   32'd0);
    check("rst out_last",  32'(bus.out_last),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post-rst in_ready", 32'(bus.in_ready), 32'd1);

    // table vectors (entries with scramble alter in_data right after capture)
    for (int t = 0; t < 4; t++) run_vec(tbl[t], $sformatf("tbl%0d", t));

    // back-to-back: two vectors, no bubble
    va = {8'hFF, 8'h20, 8'h0A, 8'h07, 8'h03};
    vb = {8'h90, 8'h60, 8'h40, 8'h11, 8'h01};
    @(posedge clk); #1;
    bus.in_data   = va;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_data = vb;
    for (int p = 0; p < 2 * N; p++) begin
      @(negedge clk);
      check_elem("b2b", p % N, (p < N) ? va : vb);
      check("b2b in_ready", 32'(bus.in_ready), 32'((p % N) == N - 1));
      @(posedge clk); #1;
      if (p == N - 1) bus.in_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b done out_valid", 32'(bus.out_valid), 32'd0);

    // backpressure: elements hold while out_ready is low
    @(posedge clk); #1;
    bus.in_data  = va;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = pat[0];
    pos = 0;
    cyc = 0;
    while (pos < N && cyc < 40) begin
      @(negedge clk);
      check_elem("bp", pos, va);
      check("bp in_ready", 32'(bus.in_ready), 32'((pos == N - 1) && bus.out_ready));
      if (bus.out_ready) pos++;
      cyc++;
      @(posedge clk); #1;
      bus.out_ready = pat[cyc % 12];
    end
    check("bp elements drained", 32'(pos), 32'(N));
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp done out_valid", 32'(bus.out_valid), 32'd0);

    // reset mid-stream after the second element is accepted
    @(posedge clk); #1;
    bus.in_data  = va;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      check_elem("mid", p, va);
      @(posedge clk);
    end
    #1 rst = 1'b1;
    #1;
    check("mid-rst out_valid", 32'(bus.out_valid), 32'd0);
    check("mid-rst out_data",  32'(bus.out_data),  32'd0);
    check("mid-rst out_last",  32'(bus.out_last),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mid-rst residual", 32'(bus.out_valid), 32'd0);
      check("mid-rst in_ready", 32'(bus.in_ready), 32'd1);
    end
    run_vec(tbl[2], "after-rst");

    // random traffic against the queue model
    pend = 1'b0;
    pv   = '0;
    for (int c = 0; c < 1200; c++) begin
      @(posedge clk); #1;
      if (!pend && c < 1000 && $urandom_range(0, 3) != 0) begin
        pv   = rand_sorted();
        pend = 1'b1;
      end
      bus.in_data   = pv;
      bus.in_valid  = pend && ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      ev  = (q.size() > 0);
      eir = (q.size() == 0) || (q.size() == 1 && bus.out_ready);
      check("rnd out_valid", 32'(bus.out_valid), 32'(ev));
      check("rnd in_ready",  32'(bus.in_ready),  32'(eir));
      if (ev) begin
        check("rnd data", 32'(bus.out_data), 32'(q[0].d));
        check("rnd idx",  32'(bus.out_idx),  32'(q[0].i));
        check("rnd last", 32'(bus.out_last), 32'(q[0].l));
        if (bus.out_ready) void'(q.pop_front());
      end
      if (bus.in_valid && eir) begin
        for (int p = 0; p < N; p++)
          q.push_back('{d: pv[rank_at(p)], i: IW'(rank_at(p)), l: (p == N - 1)});
        pend = 1'b0;
      end
      if (c >= 1000 && q.size() == 0 && !pend) break;
    end
    check("rnd drained", 32'(q.size()), 32'd0);
    bus.in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
